cache_req_arbiter: RTL and testbench

Round-robin arbiter sharing the single cache command/response channel of the memory interface among NUM_REQ requesters (host bus, TTL sweeper, debug port, ...).
- Grants one requester at a time and registers that requester's command.
- Holds all command fields stable until the response returns, because the downstream interface samples key, write flag, value and TTL in different cycles.
- Captures the response and routes it back to the granted requester only.
- Exactly one transaction is in flight at any time.

---
 rtl/cache_pkg.sv | 32 +++
 rtl/cache_req_arbiter_rr_pick.sv | 48 ++++
 rtl/cache_req_arbiter.sv | 272 +++++++++++++++++++++++++++
 tb/tb_cache_req_arbiter.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cache_pkg
// Purpose : Shared constants for the cache request arbiter slice.
//           - Default widths used by the memory interface.
//           - State encoding of the arbiter FSM.
// Revision: 1.0 - initial release
// ============================================================================
package cache_pkg;

  // Default widths shared with the memory interface
  localparam int DEF_NUM_REQ        = 4;
  localparam int DEF_KEY_WIDTH      = 64;
  localparam int DEF_VALUE_WIDTH    = 64;
  localparam int DEF_TTL_WIDTH      = 32;
  localparam int DEF_TIMEOUT_CYCLES = 255;

  // Arbiter state encoding
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_ISSUE     = 2'd1;
  localparam logic [1:0] ST_WAIT_RESP = 2'd2;
  localparam logic [1:0] ST_DELIVER   = 2'd3;

  typedef enum logic [1:0] {
    IDLE      = ST_IDLE,
    ISSUE     = ST_ISSUE,
    WAIT_RESP = ST_WAIT_RESP,
    DELIVER   = ST_DELIVER
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/cache_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick
// Purpose : Purely combinational round-robin picker.
//           The search starts at last+1 and wraps modulo N.
// Ports   : req  [N-1:0]   in   request vector
//           last [IDW-1:0] in   index of the previous grant
//           gnt  [N-1:0]   out  one-hot winner (0 when no request)
//           idx  [IDW-1:0] out  index of the winner
//           any            out  at least one request present
// Revision: 1.0 - initial release
// ============================================================================
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] last,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int unsigned    cand;
  logic [IDW-1:0] cand_id;

  // Walk offsets 1..N from the last grant.
  // Offset N lands back on last itself, so a lone requester can win
  // back-to-back.
  always_comb begin
    gnt     = '0;
    idx     = '0;
    any     = 1'b0;
    cand    = 0;
    cand_id = '0;
    for (int k = 1; k <= N; k++) begin
      cand    = (32'(last) + 32'(k)) % 32'(N);
      cand_id = IDW'(cand);
      if (!any && req[cand_id]) begin
        any          = 1'b1;
        idx          = cand_id;
        gnt[cand_id] = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : cache_req_arbiter
// Purpose : Round-robin arbiter sharing one cache command/response channel
//           among NUM_REQ requesters. Exactly one transaction is in flight.
//           The command payload is held stable until the response returns,
//           because the downstream interface samples its fields in
//           different cycles.
// Ports   : req_*   requester command side (packed per requester)
//           rsp_*   response back to the granted requester
//           cmd_*   downstream command
//           resp_*  downstream response
//           busy, grant_id  status
// Options : CACHE_ARB_WATCHDOG_EN - when defined, a WAIT_RESP watchdog of
//           TIMEOUT_CYCLES cycles delivers an error response (rsp_err=1).
//           When undefined, rsp_err is tied 0.
// Revision: 1.0 - initial release
// ============================================================================
module cache_req_arbiter
  import cache_pkg::*;
#(
  parameter int NUM_REQ        = DEF_NUM_REQ,
  parameter int KEY_WIDTH      = DEF_KEY_WIDTH,
  parameter int VALUE_WIDTH    = DEF_VALUE_WIDTH,
  parameter int TTL_WIDTH      = DEF_TTL_WIDTH,
  parameter int ID_WIDTH       = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                           clk,
  input  logic                           rst_n,
  // requester side
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*KEY_WIDTH-1:0]   req_key,
  input  logic [NUM_REQ*VALUE_WIDTH-1:0] req_value,
  input  logic [NUM_REQ*TTL_WIDTH-1:0]   req_ttl,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             rsp_valid,
  output logic                           rsp_hit,
  output logic [VALUE_WIDTH-1:0]         rsp_value,
  output logic [TTL_WIDTH-1:0]           rsp_ttl,
  output logic                           rsp_err,
  input  logic [NUM_REQ-1:0]             rsp_ready,
  // downstream side
  output logic                           cmd_valid,
  output logic                           cmd_write,
  output logic [KEY_WIDTH-1:0]           cmd_key,
  output logic [VALUE_WIDTH-1:0]         cmd_value,
  output logic [TTL_WIDTH-1:0]           cmd_ttl,
  input  logic                           cmd_ready,
  input  logic                           resp_valid,
  input  logic                           resp_hit,
  input  logic [VALUE_WIDTH-1:0]         resp_value,
  input  logic [TTL_WIDTH-1:0]           resp_ttl,
  output logic                           resp_ready,
  // status
  output logic                           busy,
  output logic [ID_WIDTH-1:0]            grant_id
);

  localparam logic [ID_WIDTH-1:0] LAST_RESET = ID_WIDTH'(NUM_REQ - 1);

  // --------------------------------------------------------------------------
  // Unpack the per-requester payloads
  // --------------------------------------------------------------------------
  logic [KEY_WIDTH-1:0]   key_arr   [NUM_REQ];
  logic [VALUE_WIDTH-1:0] value_arr [NUM_REQ];
  logic [TTL_WIDTH-1:0]   ttl_arr   [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign key_arr[gi]   = req_key[gi*KEY_WIDTH +: KEY_WIDTH];
    assign value_arr[gi] = req_value[gi*VALUE_WIDTH +: VALUE_WIDTH];
    assign ttl_arr[gi]   = req_ttl[gi*TTL_WIDTH +: TTL_WIDTH];
  end

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  arb_state_e               state_q, state_d;
  logic [ID_WIDTH-1:0]      last_grant_q, last_grant_d;
  logic [ID_WIDTH-1:0]      grant_id_q, grant_id_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic                     cmd_write_q, cmd_write_d;
  logic [KEY_WIDTH-1:0]     cmd_key_q, cmd_key_d;
  logic [VALUE_WIDTH-1:0]   cmd_value_q, cmd_value_d;
  logic [TTL_WIDTH-1:0]     cmd_ttl_q, cmd_ttl_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic                     rsp_hit_q, rsp_hit_d;
  logic [VALUE_WIDTH-1:0]   rsp_value_q, rsp_value_d;
  logic [TTL_WIDTH-1:0]     rsp_ttl_q, rsp_ttl_d;

`ifdef CACHE_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt_q, wd_cnt_d;
  logic            rsp_err_q, rsp_err_d;
`else
  // The watchdog limit has no meaning in this build.
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // --------------------------------------------------------------------------
  // Round-robin winner
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_WIDTH-1:0] pick_idx;
  logic                pick_any;

  rr_pick #(
    .N   (NUM_REQ),
    .IDW (ID_WIDTH)
  ) u_rr_pick (
    .req  (req_valid),
    .last (last_grant_q),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // --------------------------------------------------------------------------
  // Next-state and output logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_write_d  = cmd_write_q;
    cmd_key_d    = cmd_key_q;
    cmd_value_d  = cmd_value_q;
    cmd_ttl_d    = cmd_ttl_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_hit_d    = rsp_hit_q;
    rsp_value_d  = rsp_value_q;
    rsp_ttl_d    = rsp_ttl_q;
`ifdef CACHE_ARB_WATCHDOG_EN
    wd_cnt_d     = wd_cnt_q;
    rsp_err_d    = rsp_err_q;
`endif
    req_ready    = '0;
    resp_ready   = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = pick_gnt;
        if (pick_any) begin
          grant_id_d  = pick_idx;
          cmd_valid_d = 1'b1;
          cmd_write_d = req_write[pick_idx];
          cmd_key_d   = key_arr[pick_idx];
          cmd_value_d = value_arr[pick_idx];
          cmd_ttl_d   = ttl_arr[pick_idx];
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        if (cmd_valid_q && cmd_ready) begin
          cmd_valid_d = 1'b0;
          state_d     = WAIT_RESP;
`ifdef CACHE_ARB_WATCHDOG_EN
          wd_cnt_d    = '0;
`endif
        end
      end

      WAIT_RESP: begin
        resp_ready = resp_valid;
        if (resp_valid) begin
          // A response in the same cycle as the timeout takes priority.
          rsp_hit_d               = resp_hit;
          rsp_value_d             = resp_value;
          rsp_ttl_d               = resp_ttl;
          rsp_valid_d             = '0;
          rsp_valid_d[grant_id_q] = 1'b1;
          state_d                 = DELIVER;
`ifdef CACHE_ARB_WATCHDOG_EN
          rsp_err_d               = 1'b0;
`endif
        end
`ifdef CACHE_ARB_WATCHDOG_EN
        else if (wd_cnt_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          // Counter would reach TIMEOUT_CYCLES on this edge.
          rsp_hit_d               = 1'b0;
          rsp_value_d             = '0;
          rsp_ttl_d               = '0;
          rsp_err_d               = 1'b1;
          rsp_valid_d             = '0;
          rsp_valid_d[grant_id_q] = 1'b1;
          state_d                 = DELIVER;
        end else begin
          wd_cnt_d = wd_cnt_q + 1'b1;
        end
`endif
      end

      DELIVER: begin
        // Only the granted requester's accept completes the transaction.
        if (rsp_ready[grant_id_q]) begin
          rsp_valid_d  = '0;
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RESET;
      grant_id_q   <= '0;
      cmd_valid_q  <= 1'b0;
      cmd_write_q  <= 1'b0;
      cmd_key_q    <= '0;
      cmd_value_q  <= '0;
      cmd_ttl_q    <= '0;
      rsp_valid_q  <= '0;
      rsp_hit_q    <= 1'b0;
      rsp_value_q  <= '0;
      rsp_ttl_q    <= '0;
`ifdef CACHE_ARB_WATCHDOG_EN
      wd_cnt_q     <= '0;
      rsp_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_write_q  <= cmd_write_d;
      cmd_key_q    <= cmd_key_d;
      cmd_value_q  <= cmd_value_d;
      cmd_ttl_q    <= cmd_ttl_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_hit_q    <= rsp_hit_d;
      rsp_value_q  <= rsp_value_d;
      rsp_ttl_q    <= rsp_ttl_d;
`ifdef CACHE_ARB_WATCHDOG_EN
      wd_cnt_q     <= wd_cnt_d;
      rsp_err_q    <= rsp_err_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign cmd_valid = cmd_valid_q;
  assign cmd_write = cmd_write_q;
  assign cmd_key   = cmd_key_q;
  assign cmd_value = cmd_value_q;
  assign cmd_ttl   = cmd_ttl_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_value = rsp_value_q;
  assign rsp_ttl   = rsp_ttl_q;
  assign busy      = (state_q != IDLE);
  assign grant_id  = grant_id_q;
`ifdef CACHE_ARB_WATCHDOG_EN
  assign rsp_err   = rsp_err_q;
`else
  assign rsp_err   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cache_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_cache_req_arbiter
// Purpose : Directed self-checking bench for cache_req_arbiter (4 requesters).
// Revision: 1.0 - initial release
// ============================================================================
module tb_cache_req_arbiter;

  localparam int NR   = 4;
  localparam int KW   = 64;
  localparam int VW   = 64;
  localparam int TW   = 32;
  localparam int IDW  = 2;
  localparam int TOUT = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_write;
  logic [NR*KW-1:0]  req_key;
  logic [NR*VW-1:0]  req_value;
  logic [NR*TW-1:0]  req_ttl;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     rsp_valid;
  logic              rsp_hit;
  logic [VW-1:0]     rsp_value;
  logic [TW-1:0]     rsp_ttl;
  logic              rsp_err;
  logic [NR-1:0]     rsp_ready;
  logic              cmd_valid;
  logic              cmd_write;
  logic [KW-1:0]     cmd_key;
  logic [VW-1:0]     cmd_value;
  logic [TW-1:0]     cmd_ttl;
  logic              cmd_ready;
  logic              resp_valid;
  logic              resp_hit;
  logic [VW-1:0]     resp_value;
  logic [TW-1:0]     resp_ttl;
  logic              resp_ready;
  logic              busy;
  logic [IDW-1:0]    grant_id;

  int n_tests = 0;
  int n_fail  = 0;

  // Per-requester payload table
  logic [KW-1:0] exp_key   [NR];
  logic [VW-1:0] exp_value [NR];
  logic [TW-1:0] exp_ttl   [NR];
  logic [NR-1:0] wr_vec;

  always #5 clk = ~clk;

  cache_req_arbiter #(
    .NUM_REQ        (NR),
    .KEY_WIDTH      (KW),
    .VALUE_WIDTH    (VW),
    .TTL_WIDTH      (TW),
    .ID_WIDTH       (IDW),
    .TIMEOUT_CYCLES (TOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_write  (req_write),
    .req_key    (req_key),
    .req_value  (req_value),
    .req_ttl    (req_ttl),
    .req_ready  (req_ready),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .rsp_value  (rsp_value),
    .rsp_ttl    (rsp_ttl),
    .rsp_err    (rsp_err),
    .rsp_ready  (rsp_ready),
    .cmd_valid  (cmd_valid),
    .cmd_write  (cmd_write),
    .cmd_key    (cmd_key),
    .cmd_value  (cmd_value),
    .cmd_ttl    (cmd_ttl),
    .cmd_ready  (cmd_ready),
    .resp_valid (resp_valid),
    .resp_hit   (resp_hit),
    .resp_value (resp_value),
    .resp_ttl   (resp_ttl),
    .resp_ready (resp_ready),
    .busy       (busy),
    .grant_id   (grant_id)
  );

  task automatic check_value(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction. Caller sets req_valid pattern, expected winner,
  // command stall cycles, response-stall cycles and the downstream response.
  task automatic run_txn(input logic [NR-1:0] reqv, input int id,
                         input int cstall, input int rstall,
                         input logic hit, input logic [VW-1:0] rv,
                         input logic [TW-1:0] rt);
    logic [NR-1:0] oh;
    oh = 4'b0001 << id;
    req_valid = reqv;
    #1;
    check_value("req_ready_idle", req_ready, oh);
    check_value("busy_idle", busy, 0);
    @(posedge clk); #1;
    check_value("cmd_valid_issue", cmd_valid, 1);
    check_value("cmd_write", cmd_write, wr_vec[id]);
    check_value("cmd_key", cmd_key, exp_key[id]);
    check_value("cmd_value", cmd_value, exp_value[id]);
    check_value("cmd_ttl", cmd_ttl, exp_ttl[id]);
    check_value("grant_id", grant_id, id);
    check_value("req_ready_busy", req_ready, 0);
    for (int c = 0; c < cstall; c++) begin
      resp_valid = 1'b1;               // stray response outside WAIT_RESP
      #1;
      check_value("resp_ready_stray", resp_ready, 0);
      @(posedge clk); #1;
      check_value("cmd_valid_stall", cmd_valid, 1);
      check_value("cmd_key_stall", cmd_key, exp_key[id]);
      check_value("req_ready_stall", req_ready, 0);
    end
    resp_valid = 1'b0;
    cmd_ready  = 1'b1;
    @(posedge clk); #1;
    cmd_ready  = 1'b0;
    check_value("cmd_valid_drop", cmd_valid, 0);
    check_value("cmd_key_held", cmd_key, exp_key[id]);
    check_value("busy_wait", busy, 1);
    #1;
    check_value("resp_ready_novalid", resp_ready, 0);
    @(posedge clk); #1;
    resp_valid = 1'b1;
    resp_hit   = hit;
    resp_value = rv;
    resp_ttl   = rt;
    #1;
    check_value("resp_ready_wait", resp_ready, 1);
    check_value("cmd_ttl_held", cmd_ttl, exp_ttl[id]);
    @(posedge clk); #1;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_value = '0;
    resp_ttl   = '0;
    check_value("rsp_valid", rsp_valid, oh);
    check_value("rsp_hit", rsp_hit, hit);
    check_value("rsp_value", rsp_value, rv);
    check_value("rsp_ttl", rsp_ttl, rt);
    check_value("rsp_err", rsp_err, 0);
    for (int r = 0; r < rstall; r++) begin
      rsp_ready = ~oh;                 // other requesters' accepts are ignored
      @(posedge clk); #1;
      check_value("rsp_valid_hold", rsp_valid, oh);
    end
    rsp_ready = oh;
    @(posedge clk); #1;
    rsp_ready = '0;
    check_value("rsp_valid_done", rsp_valid, 0);
    check_value("busy_done", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      exp_key[i]   = 64'h11 * (i + 1);
      exp_value[i] = 64'hAA + 64'h11 * i;
      exp_ttl[i]   = 32'(5 + i);
      req_key[i*KW +: KW]   = exp_key[i];
      req_value[i*VW +: VW] = exp_value[i];
      req_ttl[i*TW +: TW]   = exp_ttl[i];
    end
    wr_vec     = 4'b1001;
    req_write  = wr_vec;
    rst_n      = 1'b0;
    req_valid  = '0;
    rsp_ready  = '0;
    cmd_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_hit   = 1'b0;
    resp_value = '0;
    resp_ttl   = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_value("rst_busy", busy, 0);
    check_value("rst_cmd_valid", cmd_valid, 0);
    check_value("rst_cmd_key", cmd_key, 0);
    check_value("rst_rsp_valid", rsp_valid, 0);
    check_value("rst_rsp_value", rsp_value, 0);
    check_value("rst_grant_id", grant_id, 0);
    check_value("rst_req_ready", req_ready, 0);
    check_value("rst_resp_ready", resp_ready, 0);
    rst_n = 1'b1;

    // Single write from requester 0
    run_txn(4'b0001, 0, 0, 0, 1'b1, 64'hAA, 32'd5);

    // Reset while waiting for the downstream response
    req_valid = 4'b0100;
    @(posedge clk); #1;
    req_valid = '0;
    check_value("mid_grant", grant_id, 2);
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    check_value("mid_busy", busy, 1);
    resp_valid = 1'b1;
    rst_n      = 1'b0;
    #1;
    check_value("mid_rst_busy", busy, 0);
    check_value("mid_rst_cmd_key", cmd_key, 0);
    check_value("mid_rst_grant", grant_id, 0);
    check_value("mid_rst_resp_ready", resp_ready, 0);
    @(posedge clk); #1;
    check_value("mid_rst_rsp_valid", rsp_valid, 0);
    resp_valid = 1'b0;
    rst_n      = 1'b1;

    // All four requesting: rotation restarts at 0 after reset
    for (int k = 0; k < 8; k++)
      run_txn(4'b1111, k % 4, 0, 0, 1'b1, 64'h1000 + 64'(k), 32'(k));
    req_valid = '0;

    // Downstream stalls 5 cycles; requester 2 delays its accept 3 cycles; miss
    run_txn(4'b0100, 2, 5, 3, 1'b0, 64'h0, 32'h0);
    // Next after 2 is 3, then wrap to 0
    run_txn(4'b1011, 3, 0, 0, 1'b1, 64'h55, 32'd9);
    run_txn(4'b0011, 0, 0, 0, 1'b1, 64'h66, 32'd10);
    // Lone requester is granted back-to-back
    run_txn(4'b0010, 1, 0, 0, 1'b1, 64'h77, 32'd11);
    run_txn(4'b0010, 1, 0, 0, 1'b1, 64'h88, 32'd12);
    req_valid = '0;

`ifdef CACHE_ARB_WATCHDOG_EN
    // Downstream never answers: error delivered 16 cycles into WAIT_RESP
    req_valid = 4'b0001;
    @(posedge clk); #1;
    req_valid = '0;
    cmd_ready = 1'b1;
    @(posedge clk); #1;
    cmd_ready = 1'b0;
    for (int k = 1; k < TOUT; k++) begin
      @(posedge clk); #1;
      check_value("wd_no_rsp", rsp_valid, 0);
    end
    @(posedge clk); #1;
    check_value("wd_rsp_valid", rsp_valid, 4'b0001);
    check_value("wd_rsp_err", rsp_err, 1);
    check_value("wd_rsp_hit", rsp_hit, 0);
    check_value("wd_rsp_value", rsp_value, 0);
    rsp_ready = 4'b0001;
    @(posedge clk); #1;
    rsp_ready = '0;
    check_value("wd_busy_done", busy, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
